usb_cache_if_sram_rsp: RTL and testbench
========================================

Name: usb_cache_if_sram_rsp

Overview:
- Responder end of the cpu_cache_if request/response protocol: the target that the USB ROB arbiter drives in standalone and IP-level benches, and in configurations without a CPU NOC.
- Accepts cpu_cache_if_req_t requests and services them against a small local line array.
- Returns cpu_cache_if_resp_t responses in acceptance order, with resp_tid echoing the request's req_tid unmodified.
- Latency is fixed and programmable; outstanding requests are bounded by a credit counter.

Parameters:
- N_LINES, 16, number of lines in the local array (power of 2, ≥2).
- RESP_LAT, 2, cycles from request accept to response-valid when the response path is idle (≥1).
- N_OUTSTANDING, 4, maximum accepted-but-unreturned requests; also the response FIFO depth (≥1).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, reset.
- cache_if_req_valid, input, 1, request valid.
- cache_if_req, input, $bits(cpu_cache_if_req_t), request: req_type, req_paddr, req_data, req_mask, req_tid.
- cache_if_req_ready, output, 1, request ready.
- cache_if_resp_valid, output, 1, response valid.
- cache_if_resp, output, $bits(cpu_cache_if_resp_t), response: resp_data, resp_mask, resp_tid.
- cache_if_resp_ready, input, 1, response ready.

Behaviour:
- Clock and reset: single clock clk. rstn is synchronous and active-low.
- Reset values:
  - cache_if_req_ready=0 during reset, 1 from the first cycle after reset.
  - cache_if_resp_valid=0; cache_if_resp=0.
  - Outstanding count, pipeline valids and FIFO pointers = 0.
  - All array lines = 0.
- Widths:
  - DW = $bits(req_data); mask is one bit per byte (DW/8 bits).
  - OFS = log2(DW/8).
  - Line index = req_paddr[OFS +: log2(N_LINES)]. Higher and lower address bits are ignored, so addresses alias (wrap).
- Accept: a request is accepted when cache_if_req_valid & cache_if_req_ready.
  - cache_if_req_ready = (outstanding < N_OUTSTANDING).
  - Ready is registered-count based and does not depend on cache_if_req_valid.
- Outstanding counter:
  - +1 on accept; −1 on response handshake (resp_valid & resp_ready).
  - Both in the same cycle: no change.
  - The count never exceeds N_OUTSTANDING and never underflows.
- Request decode:
  - req_type == REQ_WRITE: write.
  - Every other req_type: read.
- Write:
  - Byte-masked update of the indexed line in the accept cycle; the new value is visible on the next cycle.
  - Response: resp_data = post-write line, resp_mask = req_mask.
- Read:
  - Line is sampled in the accept cycle.
  - Response: resp_data = line contents, resp_mask = req_mask.
  - A read accepted the cycle after a write to the same line returns the written data.
- Response tag: resp_tid = req_tid (src, tid, cpu_noc_id) exactly as received.
- Pipeline:
  - Accepted request info passes through RESP_LAT−1 register stages, then is pushed into the response FIFO (depth N_OUTSTANDING).
  - The FIFO head drives cache_if_resp_valid and cache_if_resp.
  - The credit scheme guarantees no FIFO overflow; a push with the FIFO full is an assertion failure.
- Latency:
  - Accept at cycle T with an empty FIFO: resp_valid rises at T+RESP_LAT.
  - Back-to-back accepts produce back-to-back responses when resp_ready stays high (throughput 1 per cycle if N_OUTSTANDING ≥ RESP_LAT+1).
- Ordering: responses are returned strictly in acceptance order.
- Backpressure:
  - While resp_valid & ~resp_ready, cache_if_resp holds stable and valid does not drop.
  - The pipeline keeps draining into the FIFO.
- FIFO boundaries:
  - Simultaneous push and pop on a full FIFO is legal.
  - Simultaneous push and pop on an empty FIFO is illegal at RESP_LAT≥1, because a pop requires the head to be valid.
  - Pointers wrap modulo N_OUTSTANDING.
- Reset mid-operation: in-flight pipeline and FIFO contents are discarded, resp_valid = 0 the next cycle, and the array is cleared to 0.

Test Plan:
- Write line 3 (req_paddr = 3<<OFS, data=0xA5 per byte, mask all ones, tid.src=1, tid=7), then read the same address → read resp_data all 0xA5, resp_tid.src=1, tid=7, each resp_valid exactly 2 cycles after its accept.
- Partial write: mask=0x…0001, data byte0=0x5A to line 0, then read → byte0=0x5A and all other bytes 0.
- Alias: write at index N_LINES+2 → a read at index 2 returns the written data.
- Hold resp_ready=0 and issue 6 reads → exactly 4 accepted, req_ready=0 after the 4th. Raise resp_ready → 4 responses come out in order with tids 0..3, req_ready returns 1 the cycle after the first pop.
- Continuous valid with resp_ready=1 → one accept and one response per cycle in steady state, outstanding stays at 2, tids increment in order.
- Assert rstn=0 with 3 requests in flight → resp_valid=0 next cycle, no stale responses after release, and a read of a previously written line returns 0.

Source files
------------

// File: rtl/usb_cache_if_sram_rsp.sv
// Responder end of the cpu_cache_if request/response protocol: services requests against a
// small local line array and returns in-order responses after a fixed programmable latency.
package usb_cache_if_pkg;
    localparam int CACHE_IF_DW = 64;
    localparam int CACHE_IF_AW = 40;

    typedef enum logic [1:0] {
        REQ_READ    = 2'd0,
        REQ_WRITE   = 2'd1,
        REQ_READ_EX = 2'd2,
        REQ_FLUSH   = 2'd3
    } req_type_e;

    typedef struct packed {
        logic [3:0] src;
        logic [7:0] tid;
        logic [3:0] cpu_noc_id;
    } cpu_cache_if_tid_t;

    typedef struct packed {
        req_type_e                  req_type;
        logic [CACHE_IF_AW-1:0]     req_paddr;
        logic [CACHE_IF_DW-1:0]     req_data;
        logic [CACHE_IF_DW/8-1:0]   req_mask;
        cpu_cache_if_tid_t          req_tid;
    } cpu_cache_if_req_t;

    typedef struct packed {
        logic [CACHE_IF_DW-1:0]     resp_data;
        logic [CACHE_IF_DW/8-1:0]   resp_mask;
        cpu_cache_if_tid_t          resp_tid;
    } cpu_cache_if_resp_t;
endpackage

module usb_cache_if_sram_rsp
    import usb_cache_if_pkg::*;
#(
    parameter int N_LINES       = 16,
    parameter int RESP_LAT      = 2,
    parameter int N_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cache_if_req_valid,
    input  cpu_cache_if_req_t  cache_if_req,
    output logic               cache_if_req_ready,
    output logic               cache_if_resp_valid,
    output cpu_cache_if_resp_t cache_if_resp,
    input  logic               cache_if_resp_ready
);
    localparam int DW  = CACHE_IF_DW;
    localparam int NB  = DW / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(N_LINES);
    localparam int CW  = $clog2(N_OUTSTANDING + 1);
    localparam int PW  = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;

    logic [DW-1:0]      lines [N_LINES];
    logic [CW-1:0]      outstanding;
    logic               live;
    logic               accept, pop, push, is_write;
    logic [IW-1:0]      idx;
    logic [DW-1:0]      line_cur, merged;
    cpu_cache_if_resp_t acc_entry, push_entry;

    cpu_cache_if_resp_t fifo [N_OUTSTANDING];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      fifo_cnt;

    // Ready is held low through reset and comes up the first cycle after release.
    assign cache_if_req_ready = live && (outstanding < CW'(N_OUTSTANDING));
    assign accept   = cache_if_req_valid && cache_if_req_ready;
    assign pop      = cache_if_resp_valid && cache_if_resp_ready;
    assign idx      = cache_if_req.req_paddr[OFS +: IW];
    assign is_write = (cache_if_req.req_type == REQ_WRITE);
    assign line_cur = lines[idx];

    always_comb begin
        merged = line_cur;
        for (int b = 0; b < NB; b++) begin
            if (cache_if_req.req_mask[b]) merged[b*8 +: 8] = cache_if_req.req_data[b*8 +: 8];
        end
        acc_entry.resp_data = is_write ? merged : line_cur;
        acc_entry.resp_mask = cache_if_req.req_mask;
        acc_entry.resp_tid  = cache_if_req.req_tid;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_LINES; i++) lines[i] <= '0;
        end else if (accept && is_write) begin
            lines[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            live        <= 1'b0;
            outstanding <= '0;
        end else begin
            live <= 1'b1;
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    generate
        if (RESP_LAT > 1) begin : g_pipe
            cpu_cache_if_resp_t    stg   [RESP_LAT-1];
            logic [RESP_LAT-2:0]   stg_v;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    stg_v <= '0;
                    for (int i = 0; i < RESP_LAT-1; i++) stg[i] <= '0;
                end else begin
                    stg_v[0] <= accept;
                    stg[0]   <= acc_entry;
                    for (int i = 1; i < RESP_LAT-1; i++) begin
                        stg_v[i] <= stg_v[i-1];
                        stg[i]   <= stg[i-1];
                    end
                end
            end

            assign push       = stg_v[RESP_LAT-2];
            assign push_entry = stg[RESP_LAT-2];
        end else begin : g_nopipe
            assign push       = accept;
            assign push_entry = acc_entry;
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < N_OUTSTANDING; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_entry;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign cache_if_resp_valid = (fifo_cnt != '0);
    assign cache_if_resp       = cache_if_resp_valid ? fifo[rd_ptr] : '0;

    // The credit counter must keep the FIFO from ever overflowing.
    always_ff @(posedge clk) begin
        if (rstn) assert (!(push && !pop && (fifo_cnt == CW'(N_OUTSTANDING))));
    end
endmodule

// File: tb/tb_usb_cache_if_sram_rsp.sv
// Scoreboard bench for usb_cache_if_sram_rsp: directed requests push expected responses,
// a negedge monitor pops and compares data, mask, tag and latency.
module tb_usb_cache_if_sram_rsp;
    import usb_cache_if_pkg::*;

    logic               clk = 1'b0;
    logic               rstn;
    logic               cache_if_req_valid;
    cpu_cache_if_req_t  cache_if_req;
    logic               cache_if_req_ready;
    logic               cache_if_resp_valid;
    cpu_cache_if_resp_t cache_if_resp;
    logic               cache_if_resp_ready;

    usb_cache_if_sram_rsp #(.N_LINES(16), .RESP_LAT(2), .N_OUTSTANDING(4)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cache_if_req_valid  (cache_if_req_valid),
        .cache_if_req        (cache_if_req),
        .cache_if_req_ready  (cache_if_req_ready),
        .cache_if_resp_valid (cache_if_resp_valid),
        .cache_if_resp       (cache_if_resp),
        .cache_if_resp_ready (cache_if_resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]       data;
        logic [7:0]        mask;
        cpu_cache_if_tid_t tid;
        bit                chk_lat;
        int                acc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    localparam logic [63:0] A5S = {8{8'hA5}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cpu_cache_if_tid_t mk_tid(input int src, input int tid);
        cpu_cache_if_tid_t t;
        t.src        = 4'(src);
        t.tid        = 8'(tid);
        t.cpu_noc_id = 4'(src + 2);
        return t;
    endfunction

    always @(negedge clk) begin
        if (rstn && cache_if_resp_valid && cache_if_resp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got tid %h with empty scoreboard (cycle %0d)",
                         cache_if_resp.resp_tid, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_data", cache_if_resp.resp_data, e.data);
                check("resp_mask", 64'(cache_if_resp.resp_mask), 64'(e.mask));
                check("resp_tid", 64'(cache_if_resp.resp_tid), 64'(e.tid));
                if (e.chk_lat) check("resp_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    task automatic send(input req_type_e t, input logic [39:0] addr, input logic [63:0] data,
                        input logic [7:0] mask, input cpu_cache_if_tid_t tid,
                        input logic [63:0] exp_data, input bit chk_lat);
        bit ok = 0;
        int w = 0;
        cache_if_req.req_type  = t;
        cache_if_req.req_paddr = addr;
        cache_if_req.req_data  = data;
        cache_if_req.req_mask  = mask;
        cache_if_req.req_tid   = tid;
        cache_if_req_valid     = 1'b1;
        while (!ok && w < 50) begin
            @(negedge clk);
            if (cache_if_req_ready) ok = 1;
            else w++;
        end
        if (ok) begin
            sbq.push_back('{data: exp_data, mask: mask, tid: tid, chk_lat: chk_lat, acc: cyc});
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready within 50 cycles, required accept");
        end
        @(posedge clk);
        #1 cache_if_req_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int not_ready;
        int it;
        rstn                = 1'b0;
        cache_if_req_valid  = 1'b0;
        cache_if_req        = '0;
        cache_if_resp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(cache_if_req_ready), 64'd0);
        check("rst_resp_valid", 64'(cache_if_resp_valid), 64'd0);
        check("rst_resp", 64'(cache_if_resp), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_req_ready", 64'(cache_if_req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full write then back-to-back read of line 3
        send(REQ_WRITE, 40'(3 << 3), A5S, 8'hFF, mk_tid(1, 7), A5S, 1);
        send(REQ_READ,  40'(3 << 3), 64'h0, 8'hFF, mk_tid(1, 7), A5S, 1);
        drain();

        // Partial write to line 0
        send(REQ_WRITE, 40'h0, 64'hFFFF_FFFF_FFFF_FF5A, 8'h01, mk_tid(0, 1), 64'h5A, 1);
        send(REQ_READ,  40'h0, 64'h0, 8'hFF, mk_tid(0, 2), 64'h5A, 1);
        drain();

        // Alias: index 18 lands on line 2; non-write types read
        send(REQ_WRITE, 40'(18 << 3), 64'h0123_4567_89AB_CDEF, 8'hFF, mk_tid(2, 3),
             64'h0123_4567_89AB_CDEF, 1);
        send(REQ_READ_EX, 40'(2 << 3) | 40'h7, 64'h0, 8'h0F, mk_tid(2, 4),
             64'h0123_4567_89AB_CDEF, 1);
        drain();

        // Credit limit with response backpressure
        cache_if_resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cache_if_req.req_type  = REQ_READ;
            cache_if_req.req_paddr = 40'(3 << 3);
            cache_if_req.req_data  = '0;
            cache_if_req.req_mask  = 8'hFF;
            cache_if_req.req_tid   = mk_tid(0, acc);
            cache_if_req_valid     = 1'b1;
            @(negedge clk);
            if (cache_if_req_ready) begin
                sbq.push_back('{data: A5S, mask: 8'hFF, tid: mk_tid(0, acc), chk_lat: 0, acc: cyc});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        cache_if_req_valid = 1'b0;
        check("credit_accepts", 64'(acc), 64'd4);
        @(negedge clk);
        check("credit_ready_low", 64'(cache_if_req_ready), 64'd0);
        check("credit_resp_held", 64'(cache_if_resp_valid), 64'd1);
        @(posedge clk);
        #1 cache_if_resp_ready = 1'b1;
        @(negedge clk);
        check("ready_before_pop", 64'(cache_if_req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_pop", 64'(cache_if_req_ready), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Streaming: one accept per cycle, fixed latency on every response
        acc = 0;
        not_ready = 0;
        it = 0;
        while (acc < 8 && it < 20) begin
            cache_if_req.req_type  = REQ_READ;
            cache_if_req.req_paddr = 40'h0;
            cache_if_req.req_mask  = 8'hFF;
            cache_if_req.req_tid   = mk_tid(3, 8 + acc);
            cache_if_req_valid     = 1'b1;
            @(negedge clk);
            if (cache_if_req_ready) begin
                sbq.push_back('{data: 64'h5A, mask: 8'hFF, tid: mk_tid(3, 8 + acc), chk_lat: 1, acc: cyc});
                acc++;
            end else begin
                not_ready++;
            end
            @(posedge clk);
            #1;
            it++;
        end
        cache_if_req_valid = 1'b0;
        check("stream_accepts", 64'(acc), 64'd8);
        check("stream_stalls", 64'(not_ready), 64'd0);
        drain();

        // Reset with three requests in flight
        cache_if_resp_ready = 1'b0;
        send(REQ_READ, 40'(3 << 3), 64'h0, 8'hFF, mk_tid(4, 1), A5S, 0);
        send(REQ_READ, 40'(3 << 3), 64'h0, 8'hFF, mk_tid(4, 2), A5S, 0);
        send(REQ_READ, 40'(3 << 3), 64'h0, 8'hFF, mk_tid(4, 3), A5S, 0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_resp_valid", 64'(cache_if_resp_valid), 64'd0);
        check("midrst_req_ready", 64'(cache_if_req_ready), 64'd0);
        sbq.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        cache_if_resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(REQ_READ, 40'(3 << 3), 64'h0, 8'hFF, mk_tid(5, 9), 64'h0, 1);
        send(REQ_READ, 40'(18 << 3), 64'h0, 8'hFF, mk_tid(5, 10), 64'h0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
